// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and a
// parity helper, shared by the transmitter and the future parametrised receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_tx_state_t;

  // Data narrower than MAX_DATA_BITS is zero-extended, which leaves the XOR unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input int parity);
    return (parity == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Bus-side handshake and line signals of the parametrised UART transmitter.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] din;
  logic                 wr_en;
  logic                 clken;
  logic                 tx;
  logic                 tx_busy;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 overflow;

  modport master (
    output din, wr_en, clken,
    input  tx, tx_busy, fifo_full, fifo_empty, overflow
  );

  modport slave (
    input  din, wr_en, clken,
    output tx, tx_busy, fifo_full, fifo_empty, overflow
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock write FIFO with extra-MSB pointers and registered full/empty flags.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Flags come from registers, so a push against a full FIFO is refused even
  // when a pop frees an entry in the same cycle.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
              (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    empty_d = (wr_ptr_d == rd_ptr_d);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // NOTE: storage is not reset; pointers define validity, and a reset-free array maps onto plain RAM/flops.
  always_ff @(posedge clk_50m) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: write FIFO feeding a start/data/parity/stop
// serialiser that advances one bit per clken baud tick.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  uart_tx_param_if.slave   bus
);

  localparam int BW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be PAR_NONE, PAR_ODD or PAR_EVEN");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx_param: FIFO_DEPTH must be a power of two and at least 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BW-1:0]        bitpos_q, bitpos_d;
  logic [1:0]           stop_cnt_q, stop_cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_50m (clk_50m),
    .rst_n   (rst_n),
    .push_i  (bus.wr_en),
    .pop_i   (fifo_pop),
    .data_i  (bus.din),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bitpos_d   = bitpos_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    fifo_pop   = 1'b0;

    unique case (state_q)
      // Loading does not wait for a tick, so the start bit can leave on the very next one.
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_d    = fifo_dout;
          par_d      = parity_bit(MAX_DATA_BITS'(fifo_dout), PARITY);
          bitpos_d   = '0;
          stop_cnt_d = '0;
          state_d    = ST_START;
        end
      end
      ST_START: begin
        if (bus.clken) begin
          tx_d    = 1'b0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bus.clken) begin
          tx_d = shift_q[bitpos_q];
          if (bitpos_q == BW'(DATA_BITS - 1)) begin
            state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bitpos_d = bitpos_q + BW'(1);
          end
        end
      end
      ST_PAR: begin
        if (bus.clken) begin
          tx_d    = par_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bus.clken) begin
          tx_d       = 1'b1;
          stop_cnt_d = stop_cnt_q + 2'd1;
          if (stop_cnt_q == 2'(STOP_BITS - 1)) state_d = ST_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bitpos_q   <= '0;
      stop_cnt_q <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bitpos_q   <= bitpos_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      overflow_q <= bus.wr_en && fifo_full;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = (state_q != ST_IDLE) || !fifo_empty;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: five transmitter configurations share clock, reset and
// baud tick; each line is compared tick by tick with a queue of expected levels.
module tb_uart_tx_param;
  import uart_pkg::*;

  localparam int N = 5;
  localparam int DB  [N] = '{8, 7, 7, 8, 9};
  localparam int PAR [N] = '{PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE, PAR_ODD};
  localparam int SB  [N] = '{1, 1, 1, 2, 2};
  localparam int DP  [N] = '{4, 4, 4, 4, 2};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clken;
  logic [8:0]   din;
  logic [N-1:0] wr_en;
  logic [N-1:0] tx_w, busy_w, full_w, empty_w, ovf_w;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_ticks   = 0;

  // Expected line level for each upcoming tick; an empty queue means idle (1).
  bit exp_q [N][$];

  always #10 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    uart_tx_param_if #(.DATA_BITS(DB[g])) bus ();
    assign bus.din    = din[DB[g]-1:0];
    assign bus.wr_en  = wr_en[g];
    assign bus.clken  = clken;
    assign tx_w[g]    = bus.tx;
    assign busy_w[g]  = bus.tx_busy;
    assign full_w[g]  = bus.fifo_full;
    assign empty_w[g] = bus.fifo_empty;
    assign ovf_w[g]   = bus.overflow;

    uart_tx_param #(
      .DATA_BITS  (DB[g]),
      .PARITY     (PAR[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DP[g])
    ) dut (
      .clk_50m (clk),
      .rst_n   (rst_n),
      .bus     (bus)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int flen(input int k);
    return 1 + DB[k] + ((PAR[k] != PAR_NONE) ? 1 : 0) + SB[k];
  endfunction

  function automatic bit pending();
    for (int k = 0; k < N; k++) if (exp_q[k].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Literal frame, LSB first.
  task automatic push_bits(input int k, input logic [15:0] vec, input int n);
    for (int i = 0; i < n; i++) exp_q[k].push_back(vec[i]);
  endtask

  // Reference frame built from the framing rules.
  task automatic push_word(input int k, input logic [8:0] w);
    bit x = 1'b0;
    exp_q[k].push_back(1'b0);
    for (int i = 0; i < DB[k]; i++) begin
      exp_q[k].push_back(w[i]);
      x ^= w[i];
    end
    if (PAR[k] == PAR_EVEN) exp_q[k].push_back(x);
    if (PAR[k] == PAR_ODD)  exp_q[k].push_back(~x);
    for (int i = 0; i < SB[k]; i++) exp_q[k].push_back(1'b1);
  endtask

  task automatic write(input int k, input logic [8:0] w);
    din      = w;
    wr_en[k] = 1'b1;
    @(negedge clk);
    wr_en    = '0;
  endtask

  // One baud tick after 'idle' low cycles; checks every line one cycle later.
  task automatic tick(input int idle);
    repeat (idle) @(negedge clk);
    clken = 1'b1;
    @(negedge clk);
    clken = 1'b0;
    n_ticks++;
    for (int k = 0; k < N; k++) begin
      bit e = 1'b1;
      if (exp_q[k].size() != 0) e = exp_q[k].pop_front();
      check($sformatf("tx%0d_tick%0d", k, n_ticks), tx_w[k], e);
      check($sformatf("busy%0d_tick%0d", k, n_ticks), busy_w[k], exp_q[k].size() != 0);
      check($sformatf("ovf%0d_tick%0d", k, n_ticks), ovf_w[k], 1'b0);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (pending() && guard < 1000) begin
      tick($urandom_range(1, 4));
      guard++;
    end
    check("drain_timeout", pending(), 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    clken = 1'b0;
    din   = '0;
    wr_en = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst_tx%0d", k), tx_w[k], 1'b1);
      check($sformatf("rst_busy%0d", k), busy_w[k], 1'b0);
      check($sformatf("rst_full%0d", k), full_w[k], 1'b0);
      check($sformatf("rst_empty%0d", k), empty_w[k], 1'b1);
      check($sformatf("rst_ovf%0d", k), ovf_w[k], 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1, 0xA5, tick every 16 cycles: 0,1,0,1,0,0,1,0,1,1.
    write(0, 9'h0A5);
    check("a5_empty", empty_w[0], 1'b0);
    check("a5_busy", busy_w[0], 1'b1);
    push_bits(0, 16'b11_0100_1010, 10);
    for (int i = 0; i < 10; i++) tick(15);

    // 7E1 and 7O1 with 0x41; two mid-frame ticks land on consecutive cycles.
    write(1, 9'h041);
    write(2, 9'h041);
    push_bits(1, 16'b10_1000_0010, 10);
    push_bits(2, 16'b11_1000_0010, 10);
    for (int i = 0; i < 10; i++) tick((i == 3 || i == 4) ? 0 : 3);

    // 8N2, 0x00 then 0xFF back to back: two stop ticks, then the next start bit.
    write(3, 9'h000);
    write(3, 9'h0FF);
    push_word(3, 9'h000);
    push_word(3, 9'h0FF);
    for (int i = 0; i < 24; i++) tick(2);

    // Depth 4, clken low: the first word moves straight into the shift
    // register, so the FIFO fills on the 5th write and the 6th is dropped.
    for (int i = 1; i <= 6; i++) begin
      logic [8:0] w = 9'($urandom);
      write(0, w);
      if (i <= 5) push_word(0, w);
      check($sformatf("fill_full_w%0d", i), full_w[0], i >= 5);
      check($sformatf("fill_ovf_w%0d", i), ovf_w[0], i == 6);
    end
    @(negedge clk);
    check("fill_ovf_one_cycle", ovf_w[0], 1'b0);
    drain();

    // Full FIFO, write in the same cycle as the IDLE pop: still dropped.
    for (int i = 0; i < 5; i++) begin
      logic [8:0] w = 9'($urandom);
      write(0, w);
      push_word(0, w);
    end
    check("pop_race_full_before", full_w[0], 1'b1);
    while (exp_q[0].size() > 4 * flen(0)) tick(2);
    write(0, 9'h1FF);
    check("pop_race_ovf", ovf_w[0], 1'b1);
    check("pop_race_full_after", full_w[0], 1'b0);
    @(negedge clk);
    check("pop_race_ovf_one_cycle", ovf_w[0], 1'b0);
    drain();

    // Random words at random times across all configurations, never overfilling.
    for (int s = 0; s < 150; s++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 2) == 0 && exp_q[k].size() + flen(k) <= DP[k] * flen(k)) begin
          logic [8:0] w = 9'($urandom);
          write(k, w);
          push_word(k, w);
        end
      end
      tick($urandom_range(1, 6));
    end
    drain();

    // Reset during the 4th data bit of 0xA5 (a 0) with two more words queued.
    write(0, 9'h0A5);
    write(0, 9'h03C);
    write(0, 9'h0C3);
    push_word(0, 9'h0A5);
    push_word(0, 9'h03C);
    push_word(0, 9'h0C3);
    for (int i = 0; i < 5; i++) tick(2);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", tx_w[0], 1'b1);
    for (int k = 0; k < N; k++) exp_q[k].delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check($sformatf("post_rst_busy%0d", k), busy_w[k], 1'b0);
      check($sformatf("post_rst_empty%0d", k), empty_w[k], 1'b1);
    end
    for (int i = 0; i < 4; i++) tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
